mem_access_unit: RTL

Data-memory access unit for the MEM stage of the 16-bit pipeline CPU. It sits directly upstream of the single-port data RAM. It accepts one load/store request at a time from the EX/MEM pipeline register over a valid/ready handshake and drives the RAM's address, data, read-enable and write-enable strobes. It also absorbs the RAM's one-cycle registered read latency and returns a formatted response. Byte stores use read-modify-write over the word-wide RAM; byte loads are lane-selected and zero- or sign-extended.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 35 +++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW_WRITE = 2'd2
  } state_t;

  localparam logic LANE_LO = 1'b0;  // bits 7:0 of the word
  localparam logic LANE_HI = 1'b1;  // bits 15:8 of the word
  localparam int   BYTE_W  = 8;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane extract/extend for loads and lane merge for byte stores.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; caller decides when the outputs are meaningful.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] q,
  input  logic                  lane,
  input  logic                  sgn,
  input  logic                  is_byte,
  input  logic [BYTE_W-1:0]     wbyte,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  logic [BYTE_W-1:0] sel;

  // Select the addressed byte, extend it for loads, and splice the store byte into the old word.
  always_comb begin
    sel        = (lane == LANE_HI) ? q[2*BYTE_W-1:BYTE_W] : q[BYTE_W-1:0];
    load_data  = q;
    merge_data = q;
    if (is_byte) begin
      load_data = {{(DATA_WIDTH-BYTE_W){sgn & sel[BYTE_W-1]}}, sel};
    end
    if (lane == LANE_HI) begin
      merge_data[2*BYTE_W-1:BYTE_W] = wbyte;
    end else begin
      merge_data[BYTE_W-1:0] = wbyte;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a single-port registered-read data RAM.
// Latency: word store / misaligned error 1 cycle; loads and byte stores 2 cycles accept-to-resp.
// Backpressure: req_ready drops for one cycle after a load or byte-store accept; stores stream.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH:0]   req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  // Lane logic hard-codes two bytes per word.
  if (DATA_WIDTH != 2*BYTE_W) begin : g_width_check
    $fatal(1, "mem_access_unit: DATA_WIDTH must be 16 for byte access support");
  end

  state_t                  state, state_nxt;
  logic                    accept, misaligned, word_store, needs_read;
  logic [ADDR_WIDTH-1:0]   sv_addr;
  logic                    sv_lane, sv_signed, sv_byte;
  logic [BYTE_W-1:0]       sv_wbyte;
  logic [DATA_WIDTH-1:0]   load_data, merge_data;

  assign req_ready  = (state == ST_IDLE) & ~reset;
  assign accept     = req_valid & req_ready;
  assign misaligned = ~req_byte & req_addr[0];
  assign word_store = req_we & ~req_byte;
  assign needs_read = accept & ~misaligned & ~word_store;

  // Both the load-format and the RMW-merge paths read the same saved lane state.
  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .q          (mem_q),
    .lane       (sv_lane),
    .sgn        (sv_signed),
    .is_byte    (sv_byte),
    .wbyte      (sv_wbyte),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and RAM strobes; strobes are killed outright while reset is high.
  always_comb begin
    state_nxt   = state;
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_address = req_addr[ADDR_WIDTH:1];
        if (accept && !misaligned) begin
          if (word_store) begin
            mem_wren = 1'b1;
            mem_data = req_wdata;
          end else begin
            mem_rden  = 1'b1;
            state_nxt = req_we ? ST_RMW_WRITE : ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: state_nxt = ST_IDLE;
      ST_RMW_WRITE: begin
        mem_address = sv_addr;
        mem_data    = merge_data;
        mem_wren    = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      mem_rden = 1'b0;
      mem_wren = 1'b0;
    end
  end

  // Capture the request fields needed after the accept cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sv_addr   <= '0;
      sv_lane   <= LANE_LO;
      sv_signed <= 1'b0;
      sv_byte   <= 1'b0;
      sv_wbyte  <= '0;
    end else if (needs_read) begin
      sv_addr   <= req_addr[ADDR_WIDTH:1];
      sv_lane   <= req_addr[0];
      sv_signed <= req_signed;
      sv_byte   <= req_byte;
      sv_wbyte  <= req_wdata[BYTE_W-1:0];
    end
  end

  // Registered response; rdata holds between responses, valid/err are single-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && misaligned) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (accept && word_store) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
          end
        end
        ST_LOAD_WAIT: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        ST_RMW_WRITE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
